// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: request, operands and destination in;
// busy/ready status and the selected result out.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic [4:0]        reg_waddr_i;
  logic              flush_i;
  logic              busy_o;
  logic              ready_o;
  logic [DATA_W-1:0] result_o;
  logic [4:0]        reg_waddr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  busy_o, ready_o, result_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output busy_o, ready_o, result_o, reg_waddr_o
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract, one quotient bit
// per cycle, sign handled by magnitude division plus final correction.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  function automatic logic [DATA_W-1:0] neg_cond(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  state_t                   state;
  logic signed [DATA_W-1:0] dvd_cap;
  logic signed [DATA_W-1:0] dvs_cap;
  logic                     is_signed;
  logic                     is_rem;
  logic [4:0]               rd_cap;
  logic [DATA_W-1:0]        quo_r;
  logic [DATA_W-1:0]        rem_r;
  logic [DATA_W-1:0]        dvs_r;
  logic [CNT_W-1:0]         cnt;
  logic                     neg_q;
  logic                     neg_r;
  logic                     busy_q;
  logic                     ready_q;
  logic [DATA_W-1:0]        result_q;
  logic [4:0]               waddr_q;

  logic                     accept;
  logic                     dvd_neg;
  logic                     dvs_neg;
  logic [DATA_W:0]          rem_sh;
  logic [DATA_W:0]          rem_diff;
  logic                     q_bit;
  logic [DATA_W-1:0]        rem_nx;
  logic [DATA_W-1:0]        quo_nx;
  logic [DATA_W-1:0]        fin_q;
  logic [DATA_W-1:0]        fin_r;

  assign accept  = bus.start_i && bus.op_i[2] && !bus.flush_i;
  assign dvd_neg = is_signed && (dvd_cap < 0);
  assign dvs_neg = is_signed && (dvs_cap < 0);

  // The dividend register doubles as the quotient register: its MSB feeds the
  // remainder and the new quotient bit enters at the LSB.
  assign rem_sh   = {rem_r, quo_r[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_r};
  assign q_bit    = (rem_sh >= {1'b0, dvs_r});
  assign rem_nx   = q_bit ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quo_nx   = {quo_r[DATA_W-2:0], q_bit};
  assign fin_q    = neg_cond(quo_nx, neg_q);
  assign fin_r    = neg_cond(rem_nx, neg_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dvd_cap   <= '0;
      dvs_cap   <= '0;
      is_signed <= 1'b0;
      is_rem    <= 1'b0;
      rd_cap    <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
      waddr_q   <= '0;
    end else if (state == S_IDLE) begin
      ready_q <= 1'b0;
      if (accept) begin
        dvd_cap   <= bus.dividend_i;
        dvs_cap   <= bus.divisor_i;
        is_signed <= ~bus.op_i[0];
        is_rem    <= bus.op_i[1];
        rd_cap    <= bus.reg_waddr_i;
        busy_q    <= 1'b1;
        state     <= S_START;
      end
    end else if (bus.flush_i) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      state   <= S_IDLE;
    end else begin
      case (state)
        S_START: begin
          if (dvs_cap == 0) begin
            result_q <= is_rem ? dvd_cap : '1;
            waddr_q  <= rd_cap;
            ready_q  <= 1'b1;
            state    <= S_END;
          end else begin
            quo_r <= neg_cond(dvd_cap, dvd_neg);
            dvs_r <= neg_cond(dvs_cap, dvs_neg);
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            rem_r <= '0;
            cnt   <= CNT_W'(DATA_W - 1);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt - CNT_W'(1);
          // Final iteration: sign-correct and publish straight from this step.
          if (cnt == '0) begin
            result_q <= is_rem ? fin_r : fin_q;
            waddr_q  <= rd_cap;
            ready_q  <= 1'b1;
            state    <= S_END;
          end
        end
        S_END: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.ready_o     = ready_q;
  assign bus.result_o    = result_q;
  assign bus.reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, div-by-zero,
// overflow, flush, ignored restarts and asynchronous reset.
module tb_div_unit;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request during the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.start_i     = 1'b1;
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = rd;
    @(posedge clk); #1;
    bus.start_i     = 1'b0;
  endtask

  // Bounded wait for ready_o; lat is the cycle number it was seen in, 0 if never.
  task automatic wait_ready(input int from, output int lat);
    lat = 0;
    for (int c = from; c <= from + 60; c++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat;
    issue(op, a, b, rd);
    wait_ready(1, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.result_o, exp_res);
    chk({tag, "_rd"}, {27'd0, bus.reg_waddr_o}, {27'd0, rd});
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bus.ready_o}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst             = 1'b0;
    bus.start_i     = 1'b0;
    bus.op_i        = 3'b000;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.reg_waddr_i = '0;
    bus.flush_i     = 1'b0;
    #2;
    chk("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("rst_res",   bus.result_o, 32'd0);
    chk("rst_rd",    {27'd0, bus.reg_waddr_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_op("div_100_7",   OP_DIV,  32'd100,      32'd7,          5'd5,  32'h0000000E, 34);
    run_op("rem_100_7",   OP_REM,  32'd100,      32'd7,          5'd6,  32'h00000002, 34);
    run_op("div_m100_7",  OP_DIV,  32'hFFFFFF9C, 32'd7,          5'd7,  32'hFFFFFFF2, 34);
    run_op("rem_m100_7",  OP_REM,  32'hFFFFFF9C, 32'd7,          5'd8,  32'hFFFFFFFE, 34);
    run_op("div_m100_m7", OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9,   5'd9,  32'h0000000E, 34);
    run_op("rem_7_m2",    OP_REM,  32'd7,        32'hFFFFFFFE,   5'd10, 32'h00000001, 34);
    run_op("div_7_m2",    OP_DIV,  32'd7,        32'hFFFFFFFE,   5'd11, 32'hFFFFFFFD, 34);
    run_op("divu_max_2",  OP_DIVU, 32'hFFFFFFFF, 32'd2,          5'd12, 32'h7FFFFFFF, 34);
    run_op("remu_max_2",  OP_REMU, 32'hFFFFFFFF, 32'd2,          5'd13, 32'h00000001, 34);
    run_op("div_by0",     OP_DIV,  32'h12345678, 32'd0,          5'd14, 32'hFFFFFFFF, 2);
    run_op("remu_by0",    OP_REMU, 32'h12345678, 32'd0,          5'd15, 32'h12345678, 2);
    run_op("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF,   5'd16, 32'h80000000, 34);
    run_op("rem_ovf",     OP_REM,  32'h80000000, 32'hFFFFFFFF,   5'd17, 32'h00000000, 34);
    run_op("divu_big",    OP_DIVU, 32'h80000000, 32'hFFFFFFFF,   5'd18, 32'h00000000, 34);
    run_op("remu_big",    OP_REMU, 32'h80000000, 32'hFFFFFFFF,   5'd19, 32'h80000000, 34);
    run_op("div_seed",    OP_DIV,  32'd100,      32'd7,          5'd1,  32'h0000000E, 34);

    // Invalid funct3 must not start anything.
    bus.op_i = 3'b011; bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(negedge clk);
    chk("badop_busy", {31'd0, bus.busy_o}, 32'd0);

    // Flush in cycle 10 aborts; result_o keeps 14; restart in cycle 11.
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd2, 5'd20);
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (bus.ready_o) seen++;
      @(posedge clk); #1;
    end
    bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    if (bus.ready_o) seen++;
    chk("flush_busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("flush_res",   bus.result_o, 32'h0000000E);
    chk("flush_noack", seen, 0);
    run_op("after_flush", OP_REM, 32'd100, 32'd7, 5'd21, 32'h00000002, 34);

    // Flush and start together in IDLE: request dropped.
    bus.flush_i = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7, 5'd22);
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk); #1;

    // Second start in cycle 5 with new operands is ignored.
    issue(OP_DIV, 32'd100, 32'd7, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    bus.start_i = 1'b1; bus.op_i = OP_DIVU;
    bus.dividend_i = 32'hFFFFFFFF; bus.divisor_i = 32'd2; bus.reg_waddr_i = 5'd23;
    @(posedge clk); #1 bus.start_i = 1'b0;
    wait_ready(6, lat);
    chk("restart_lat", lat, 34);
    chk("restart_res", bus.result_o, 32'h0000000E);
    chk("restart_rd",  {27'd0, bus.reg_waddr_o}, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_idle", {31'd0, bus.busy_o}, 32'd0);

    // Async reset in cycle 20 clears outputs at once; no ready afterwards.
    issue(OP_REMU, 32'hFFFFFFFF, 32'd2, 5'd24);
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("arst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("arst_res",   bus.result_o, 32'd0);
    chk("arst_rd",    {27'd0, bus.reg_waddr_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o || bus.busy_o) seen++;
    end
    chk("arst_quiet", seen, 0);
    @(posedge clk); #1;
    run_op("post_rst", OP_DIVU, 32'hFFFFFFFF, 32'd2, 5'd25, 32'h7FFFFFFF, 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divider serving DIV, DIVU, REM and REMU on behalf of the execute stage. Decode forwards these instructions with register write disabled and the fall-through PC prepared. Execute then starts this block, stalls the pipeline while `busy_o` is high, and writes `result_o` to `reg_waddr_o` when `ready_o` pulses. The divider uses a restoring shift-subtract algorithm and retires one quotient bit per cycle.

## Interface
- `DATA_W`, default 32: operand/result width (only 32 supported).
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request; sampled only in IDLE.
- `op_i`  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other values make `start_i` ignored.
- `dividend_i`  in  32  rs1 value.
- `divisor_i`  in  32  rs2 value.
- `reg_waddr_i`  in  5  destination register (rd).
- `flush_i`  in  1  pipeline flush (jump/interrupt); aborts the operation.
- `busy_o`  out  1  high whenever state != IDLE.
- `ready_o`  out  1  one-cycle pulse, result valid.
- `result_o`  out  32  quotient or remainder; held until the next accepted start.
- `reg_waddr_o`  out  5  captured rd, valid with `ready_o`.

## Operation
- Reset (async, `rst`=0): state IDLE, `busy_o`=0, `ready_o`=0, `result_o`=0, `reg_waddr_o`=0, and all internal registers cleared. Reset mid-operation abandons the operation with no `ready_o`.
- States: IDLE, START, CALC, END.
- IDLE: on `start_i`=1 with a valid `op_i` and `flush_i`=0, capture the operands, op and rd. Next state is START.
- START, divisor == 0: load the special result, next state END.
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → the dividend.
- START, divisor != 0:
  - For signed ops, take absolute values of both operands; for unsigned ops, use them as-is.
  - Record `neg_q` = sign(dividend) XOR sign(divisor), and `neg_r` = sign(dividend). Both are 0 for unsigned ops.
  - Clear the 32-bit partial remainder, set bit counter to 31, next state CALC.
- CALC, each cycle:
  - Shift {remainder, dividend} left by 1.
  - If shifted remainder ≥ divisor, subtract the divisor and set quotient bit to 1; otherwise quotient bit is 0.
  - Decrement the counter. After the counter-0 iteration (32 cycles total), next state END.
- END:
  - Apply sign correction: quotient negated if `neg_q`, remainder negated if `neg_r`, using two's complement mod 2^32.
  - Select quotient for DIV/DIVU and remainder for REM/REMU.
  - Drive `result_o` and `reg_waddr_o`, pulse `ready_o`, next state IDLE.
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no special path: it yields quotient 0x80000000 and remainder 0, per the RISC-V spec.
- `start_i` while not in IDLE is ignored, with no queuing.
- `flush_i`=1 in any non-IDLE state forces IDLE next cycle. No `ready_o` is produced and `result_o` keeps its old value.
- `flush_i` and `start_i` high in the same IDLE cycle: flush wins and the request is dropped.

## Timing
- Start accepted at the edge ending cycle 0. START occupies cycle 1, CALC occupies cycles 2–33, and END occupies cycle 34.
- `ready_o`=1 during cycle 34 only, for a latency of 34 cycles.
- Divide-by-zero path: START in cycle 1, END in cycle 2, so `ready_o` is high in cycle 2.
- `busy_o` is high in cycles 1 through END inclusive and low in the cycle after END. A new start is accepted in that cycle, so back-to-back throughput is one op per 35 cycles.
- `ready_o`, `result_o` and `reg_waddr_o` are driven directly by registers, with no combinational path from inputs.
- Operands are captured on acceptance, so changes to `dividend_i`, `divisor_i` or `reg_waddr_i` after cycle 0 have no effect.

## Test plan
- DIV 100/7 → `result_o`=14 (0x0000000E) with `ready_o` in cycle 34. REM with the same operands → 2.
- DIV −100 (0xFFFFFF9C) / 7 → 0xFFFFFFF2 (−14). REM → 0xFFFFFFFE (−2). DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF. REMU → 1.
- Divisor 0, dividend 0x12345678: DIV → 0xFFFFFFFF and REMU → 0x12345678, with `ready_o` in cycle 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Assert `flush_i` in cycle 10 → `busy_o`=0 in cycle 11, no `ready_o` at all, and `result_o` unchanged. A start in cycle 11 completes normally in cycle 45.
- Apply a second `start_i` with new operands in cycle 5 → it is ignored and the first result is unaffected. Pull `rst` low in cycle 20 → all outputs 0 immediately and no `ready_o`.
